// File: rtl/jedro_1_run_ctrl_if.sv
// Run-controller bus: start/halt control, core reset, check vectors, RF read port, results.
// Instantiate with the same DATA_WIDTH/NUM_CHECKS/MAX_CYCLES as the controller.
interface jedro_1_run_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CHECKS = 4,
  parameter int MAX_CYCLES = 64
);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  logic                             start_i;
  logic                             halt_i;
  logic                             core_rstn_o;
  logic [NUM_CHECKS*5-1:0]          exp_addr_i;
  logic [NUM_CHECKS*DATA_WIDTH-1:0] exp_data_i;
  logic [NUM_CHECKS-1:0]            check_en_i;
  logic [4:0]                       rf_addr_o;
  logic [DATA_WIDTH-1:0]            rf_data_i;
  logic                             done_o;
  logic                             pass_o;
  logic                             timeout_o;
  logic                             fail_o;
  logic [IDX_W-1:0]                 fail_idx_o;
  logic [DATA_WIDTH-1:0]            fail_data_o;
  logic [CNT_W-1:0]                 cycle_cnt_o;

  modport master (
    output start_i, halt_i, exp_addr_i, exp_data_i, check_en_i, rf_data_i,
    input  core_rstn_o, rf_addr_o, done_o, pass_o, timeout_o, fail_o,
           fail_idx_o, fail_data_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, halt_i, exp_addr_i, exp_data_i, check_en_i, rf_data_i,
    output core_rstn_o, rf_addr_o, done_o, pass_o, timeout_o, fail_o,
           fail_idx_o, fail_data_o, cycle_cnt_o
  );
endinterface

// File: rtl/jedro_1_run_ctrl.sv
// Test-run controller: resets the core, runs it until halt/timeout, drains, then checks registers.
// Optional macro JEDRO_1_RUN_CTRL_STOP_ON_FAIL_EN ends the check scan at the first mismatch.
module jedro_1_run_ctrl_chk #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_exp,
  input  logic [DATA_WIDTH-1:0] i_rf,
  output logic                  o_mis
);
  assign o_mis = i_en && (i_rf != i_exp);
endmodule

module jedro_1_run_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHECKS   = 4,
  parameter int RESET_CYCLES = 3,
  parameter int MAX_CYCLES   = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  jedro_1_run_ctrl_if.slave bus
);
  localparam int IDX_W    = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int CNT_W    = $clog2(MAX_CYCLES + 1);
  localparam int STEP_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  localparam logic [STEP_W-1:0] HOLD_LAST  = STEP_W'(RESET_CYCLES - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  CHK_LAST   = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t                     r_state, w_next;
  logic   [STEP_W-1:0]        r_step;
  logic   [IDX_W-1:0]         r_chk;
  logic   [CNT_W-1:0]         r_cnt;
  logic                       r_core_rstn;
  logic                       r_timeout;
  logic                       r_fail;
  logic   [IDX_W-1:0]         r_fail_idx;
  logic   [DATA_WIDTH-1:0]    r_fail_data;

  logic                        w_start;
  logic                        w_done;
  logic   [4:0]                w_rf_addr;
  logic   [NUM_CHECKS-1:0]     w_mis;
  logic                        w_cur_mis;
  logic [NUM_CHECKS-1:0][4:0]  w_addr;

  assign w_addr = bus.exp_addr_i;

  // Every channel compares against the shared read port; only the one being scanned is used.
  for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_chk
    jedro_1_run_ctrl_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
      .i_en  (bus.check_en_i[g]),
      .i_exp (bus.exp_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_rf  (bus.rf_data_i),
      .o_mis (w_mis[g])
    );
  end

  assign w_cur_mis = w_mis[r_chk];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_done    = 1'b0;
    w_rf_addr = 5'd0;
    case (r_state)
      S_IDLE: if (bus.start_i) begin
        w_next  = S_HOLD;
        w_start = 1'b1;
      end
      S_HOLD:  if (r_step == HOLD_LAST) w_next = S_RUN;
      S_RUN:   if (bus.halt_i || r_cnt == CNT_MAX) w_next = S_DRAIN;
      S_DRAIN: if (r_step == DRAIN_LAST) w_next = S_CHECK;
      S_CHECK: begin
        w_rf_addr = w_addr[r_chk];
        if (r_chk == CHK_LAST) w_next = S_DONE;
`ifdef JEDRO_1_RUN_CTRL_STOP_ON_FAIL_EN
        if (w_cur_mis) w_next = S_DONE;
`endif
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start_i) begin
          w_next  = S_HOLD;
          w_start = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_step      <= '0;
      r_chk       <= '0;
      r_cnt       <= '0;
      r_core_rstn <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
    end else begin
      // Core leaves reset on the same edge the FSM enters RUN.
      r_core_rstn <= (w_next == S_RUN) || (w_next == S_DRAIN) ||
                     (w_next == S_CHECK) || (w_next == S_DONE);
      r_step      <= (r_state == w_next) ? r_step + 1'b1 : '0;
      r_chk       <= (r_state == S_CHECK) ? r_chk + 1'b1 : '0;

      if (w_start) begin
        r_cnt       <= '0;
        r_timeout   <= 1'b0;
        r_fail      <= 1'b0;
        r_fail_idx  <= '0;
        r_fail_data <= '0;
      end

      // Halt takes priority over timeout when both land on the same cycle.
      if (r_state == S_RUN && !bus.halt_i) begin
        if (r_cnt == CNT_MAX) r_timeout <= 1'b1;
        else                  r_cnt     <= r_cnt + 1'b1;
      end

      if (r_state == S_CHECK && w_cur_mis && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_idx  <= r_chk;
        r_fail_data <= bus.rf_data_i;
      end
    end
  end

  assign bus.core_rstn_o = r_core_rstn;
  assign bus.rf_addr_o   = w_rf_addr;
  assign bus.done_o      = w_done;
  assign bus.pass_o      = w_done && !r_fail && !r_timeout;
  assign bus.timeout_o   = r_timeout;
  assign bus.fail_o      = r_fail;
  assign bus.fail_idx_o  = r_fail_idx;
  assign bus.fail_data_o = r_fail_data;
  assign bus.cycle_cnt_o = r_cnt;
endmodule
